branch_redirect_sched: RTL and testbench

- Sequences branch resolution in the ID stage of the 5-stage MIPS pipeline.
- Decides when the combinational branch comparator result is valid, inserting a load-use bubble when a branch source is still being loaded.
- Launches a registered PC redirect to the fetch unit and holds it until fetch accepts it.
- At most one redirect is ever outstanding.

---
 rtl/branch_redirect_sched.sv | 113 +++++++++++
 tb/tb_branch_redirect_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_sched.sv
// ID-stage branch resolution sequencer: load-use bubble, registered fetch redirect handshake.
// Optional branch statistics counters are built when BRANCH_STATS_EN is defined.
module branch_redirect_sched #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_in,
  input  logic             id_valid,
  input  logic             id_is_branch,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_load_valid,
  input  logic [REG_W-1:0] ex_load_rd,
  input  logic             cmp_taken,
  input  logic [PC_W-1:0]  br_target,
  input  logic             redirect_ready,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
`ifdef BRANCH_STATS_EN
  input  logic             stat_clr,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_taken,
`endif
  output logic             stall_id
);

  typedef enum logic [1:0] {StIdle, StHazard, StRedirect} state_e;

  state_e state_q;
  logic   hazard;
  logic   br_live;

  assign hazard = ex_load_valid && (ex_load_rd != '0) &&
                  ((ex_load_rd == id_rs) || (id_uses_rt && (ex_load_rd == id_rt)));
  assign br_live = id_valid && id_is_branch && !stall_in;

  // A branch behind a pending redirect waits; it re-evaluates from idle next cycle.
  always_comb begin
    stall_id = 1'b0;
    if (rst_n && br_live) begin
      unique case (state_q)
        StIdle:     stall_id = hazard;
        StRedirect: stall_id = 1'b1;
        default:    stall_id = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else if (!stall_in) begin
      unique case (state_q)
        StIdle: begin
          if (br_live) begin
            if (hazard) begin
              state_q <= StHazard;
            end else if (cmp_taken) begin
              redirect_pc    <= br_target;
              redirect_valid <= 1'b1;
              state_q        <= StRedirect;
            end
          end
        end
        StHazard: begin
          // Load has reached MEM and is forwarded, so the hazard is not re-checked.
          if (br_live && cmp_taken) begin
            redirect_pc    <= br_target;
            redirect_valid <= 1'b1;
            state_q        <= StRedirect;
          end else begin
            state_q <= StIdle;
          end
        end
        StRedirect: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic resolve;

  assign resolve = br_live &&
                   (((state_q == StIdle) && !hazard) || (state_q == StHazard));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches <= '0;
      stat_taken    <= '0;
    end else if (stat_clr) begin
      stat_branches <= '0;
      stat_taken    <= '0;
    end else if (resolve) begin
      stat_branches <= stat_branches + 32'd1;
      if (cmp_taken) begin
        stat_taken <= stat_taken + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_redirect_sched.sv
// Directed bench for branch_redirect_sched; stats checks compile when BRANCH_STATS_EN is defined.
module tb_branch_redirect_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_in;
  logic        id_valid;
  logic        id_is_branch;
  logic        id_uses_rt;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        ex_load_valid;
  logic [4:0]  ex_load_rd;
  logic        cmp_taken;
  logic [31:0] br_target;
  logic        redirect_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_id;
`ifdef BRANCH_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_branches;
  logic [31:0] stat_taken;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_redirect_sched #(.PC_W(32), .REG_W(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_in       (stall_in),
    .id_valid       (id_valid),
    .id_is_branch   (id_is_branch),
    .id_uses_rt     (id_uses_rt),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .ex_load_valid  (ex_load_valid),
    .ex_load_rd     (ex_load_rd),
    .cmp_taken      (cmp_taken),
    .br_target      (br_target),
    .redirect_ready (redirect_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef BRANCH_STATS_EN
    .stat_clr       (stat_clr),
    .stat_branches  (stat_branches),
    .stat_taken     (stat_taken),
`endif
    .stall_id       (stall_id)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic no_inst();
    id_valid      = 1'b0;
    id_is_branch  = 1'b0;
    id_uses_rt    = 1'b0;
    id_rs         = '0;
    id_rt         = '0;
    cmp_taken     = 1'b0;
    ex_load_valid = 1'b0;
    ex_load_rd    = '0;
  endtask

  task automatic branch(input logic uses_rt, input logic [4:0] rs, input logic [4:0] rt,
                        input logic taken, input logic [31:0] tgt);
    id_valid     = 1'b1;
    id_is_branch = 1'b1;
    id_uses_rt   = uses_rt;
    id_rs        = rs;
    id_rt        = rt;
    cmp_taken    = taken;
    br_target    = tgt;
  endtask

  initial begin
    rst_n          = 1'b0;
    stall_in       = 1'b0;
    redirect_ready = 1'b0;
    br_target      = '0;
`ifdef BRANCH_STATS_EN
    stat_clr       = 1'b0;
`endif
    no_inst();
    // Hazard-causing branch while reset held: stall_id must stay low.
    branch(1'b1, 5'd5, 5'd3, 1'b1, 32'h0000_0400);
    ex_load_valid = 1'b1;
    ex_load_rd    = 5'd5;
    settle();
    check("rst_rv", {31'b0, redirect_valid}, 32'd0);
    check("rst_pc", redirect_pc, 32'd0);
    check("rst_stall", {31'b0, stall_id}, 32'd0);
    tick();
    no_inst();
    rst_n = 1'b1;
    tick();

    // BEQ taken, no hazard.
    redirect_ready = 1'b1;
    branch(1'b1, 5'd1, 5'd2, 1'b1, 32'h0000_0400);
    settle();
    check("beq_stall", {31'b0, stall_id}, 32'd0);
    tick();
    no_inst();
    settle();
    check("beq_rv", {31'b0, redirect_valid}, 32'd1);
    check("beq_pc", redirect_pc, 32'h0000_0400);
    check("beq_stall2", {31'b0, stall_id}, 32'd0);
    tick();
    check("beq_rv_drop", {31'b0, redirect_valid}, 32'd0);

    // Load-use hazard on BNE rs.
    redirect_ready = 1'b0;
    branch(1'b1, 5'd5, 5'd3, 1'b0, 32'h0000_0800);
    ex_load_valid = 1'b1;
    ex_load_rd    = 5'd5;
    settle();
    check("haz_stall", {31'b0, stall_id}, 32'd1);
    tick();
    ex_load_valid = 1'b0;
    cmp_taken     = 1'b1;
    settle();
    check("haz_bubble_stall", {31'b0, stall_id}, 32'd0);
    check("haz_bubble_rv", {31'b0, redirect_valid}, 32'd0);
    tick();
    no_inst();
    settle();
    check("haz_rv", {31'b0, redirect_valid}, 32'd1);
    check("haz_pc", redirect_pc, 32'h0000_0800);
    redirect_ready = 1'b1;
    tick();
    check("haz_rv_drop", {31'b0, redirect_valid}, 32'd0);

    // BGEZ ignores rt; $0 load never hazards; non-branch never stalls.
    branch(1'b0, 5'd1, 5'd5, 1'b0, 32'h0);
    ex_load_valid = 1'b1;
    ex_load_rd    = 5'd5;
    settle();
    check("bgez_stall", {31'b0, stall_id}, 32'd0);
    tick();
    branch(1'b1, 5'd0, 5'd0, 1'b0, 32'h0);
    ex_load_rd = 5'd0;
    settle();
    check("r0_stall", {31'b0, stall_id}, 32'd0);
    tick();
    id_is_branch = 1'b0;
    id_rs        = 5'd7;
    ex_load_rd   = 5'd7;
    cmp_taken    = 1'b1;
    settle();
    check("nonbr_stall", {31'b0, stall_id}, 32'd0);
    tick();
    check("nonbr_rv", {31'b0, redirect_valid}, 32'd0);
    no_inst();

    // Back-pressure from fetch; second branch waits through the accept cycle.
    redirect_ready = 1'b0;
    branch(1'b1, 5'd1, 5'd2, 1'b1, 32'h0000_1234);
    tick();
    no_inst();
    settle();
    check("bp_pc1", redirect_pc, 32'h0000_1234);
    tick();
    check("bp_pc2", redirect_pc, 32'h0000_1234);
    branch(1'b1, 5'd3, 5'd4, 1'b1, 32'h0000_2000);
    settle();
    check("bp_stall_wait", {31'b0, stall_id}, 32'd1);
    tick();
    check("bp_pc3", redirect_pc, 32'h0000_1234);
    check("bp_rv3", {31'b0, redirect_valid}, 32'd1);
    redirect_ready = 1'b1;
    settle();
    check("bp_stall_accept", {31'b0, stall_id}, 32'd1);
    check("bp_pc4", redirect_pc, 32'h0000_1234);
    tick();
    redirect_ready = 1'b0;
    settle();
    check("bp_rv_idle", {31'b0, redirect_valid}, 32'd0);
    check("bp_stall_idle", {31'b0, stall_id}, 32'd0);
    tick();
    no_inst();
    settle();
    check("bp2_rv", {31'b0, redirect_valid}, 32'd1);
    check("bp2_pc", redirect_pc, 32'h0000_2000);

    // Freeze during REDIRECT ignores redirect_ready.
    stall_in       = 1'b1;
    redirect_ready = 1'b1;
    branch(1'b1, 5'd1, 5'd2, 1'b1, 32'h0000_9999);
    settle();
    check("frz_stall", {31'b0, stall_id}, 32'd0);
    tick();
    check("frz_rv1", {31'b0, redirect_valid}, 32'd1);
    tick();
    check("frz_rv2", {31'b0, redirect_valid}, 32'd1);
    check("frz_pc", redirect_pc, 32'h0000_2000);
    stall_in = 1'b0;
    no_inst();
    tick();
    check("frz_accept", {31'b0, redirect_valid}, 32'd0);

    // Asynchronous reset mid-REDIRECT.
    redirect_ready = 1'b0;
    branch(1'b1, 5'd1, 5'd2, 1'b1, 32'h0000_3000);
    tick();
    check("pre_rst_rv", {31'b0, redirect_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rv", {31'b0, redirect_valid}, 32'd0);
    check("async_pc", redirect_pc, 32'd0);
    check("async_stall", {31'b0, stall_id}, 32'd0);
    tick();
    rst_n = 1'b1;
    no_inst();
    tick();
    check("no_replay", {31'b0, redirect_valid}, 32'd0);

`ifdef BRANCH_STATS_EN
    check("st_rst_br", stat_branches, 32'd0);
    redirect_ready = 1'b1;
    branch(1'b1, 5'd1, 5'd2, 1'b1, 32'h100);   // 1: taken
    tick();
    no_inst();
    tick();
    branch(1'b1, 5'd1, 5'd2, 1'b0, 32'h0);     // 2: not taken
    tick();
    branch(1'b1, 5'd6, 5'd2, 1'b1, 32'h200);   // 3: hazard, then taken
    ex_load_valid = 1'b1;
    ex_load_rd    = 5'd6;
    tick();
    ex_load_valid = 1'b0;
    tick();
    no_inst();
    tick();
    branch(1'b1, 5'd1, 5'd2, 1'b0, 32'h0);     // 4: not taken
    tick();
    branch(1'b1, 5'd1, 5'd2, 1'b1, 32'h300);   // 5: taken
    tick();
    no_inst();
    tick();
    check("st_branches", stat_branches, 32'd5);
    check("st_taken", stat_taken, 32'd3);
    branch(1'b1, 5'd1, 5'd2, 1'b1, 32'h400);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    no_inst();
    check("st_clr_br", stat_branches, 32'd0);
    check("st_clr_tk", stat_taken, 32'd0);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
